regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bits per register.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers (legal 2..2**AW).
REQ-003 SHALL have parameter AW, default 5, address width.
REQ-004 SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads 0 and is never written or claimed.
REQ-005 SHALL have parameter BYPASS, default 1; when 1, same-cycle write data is forwarded to read ports.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have ports read1, read2  input  AW  read port addresses.
REQ-009 SHALL have ports read_data1, read_data2  output  WIDTH  combinational read data.
REQ-010 SHALL have ports busy1, busy2  output  1  scoreboard pending-write flag for read1/read2.
REQ-011 SHALL have ports write  input  AW, write_data  input  WIDTH, write_enable  input  1  writeback port.
REQ-012 SHALL have ports claim  input  AW, claim_enable  input  1  marks a register as awaiting a result.
REQ-013 SHALL have port busy_count  output  AW+1  number of registers currently marked busy.

Function
REQ-014 SHALL store DEPTH x WIDTH data bits and DEPTH busy bits in flops.
REQ-015 SHALL, on a clock edge with write_enable=1 and write<DEPTH, load write_data into register write and clear its busy bit.
REQ-016 SHALL, on a clock edge with claim_enable=1 and claim<DEPTH, set busy bit of register claim.
REQ-017 SHALL, when claim and write target the same register in the same cycle, leave busy=1 (claim wins) and still store write_data.
REQ-018 SHALL ignore writes and claims to addresses >= DEPTH; reads of such addresses return 0 with busy 0.
REQ-019 SHALL, when ZERO_REG=1, ignore write and claim to register 0; reads of register 0 return 0 with busy 0.
REQ-020 SHALL, when BYPASS=1, write_enable=1, reset=0 and write==readN (legal, not zero register), drive read_dataN=write_data and busyN=0 in that cycle, unless claim_enable=1 with claim==write (then busyN=1).
REQ-021 SHALL, when BYPASS=0, drive read data and busy purely from stored state (new value visible the cycle after the write edge).
REQ-022 SHALL allow read1==read2; both ports return identical data and busy.
REQ-023 SHALL update busy_count each edge to equal the population count of busy bits after that edge; maximum DEPTH, never wraps.
REQ-024 SHALL have zero-cycle read latency and one-cycle write/claim latency.

Reset
REQ-025 SHALL, on a clock edge with reset=1, clear all data registers to 0, all busy bits to 0 and busy_count to 0.
REQ-026 SHALL give reset priority over same-cycle write and claim; neither takes effect.
REQ-027 SHALL suppress bypass while reset=1; read outputs reflect stored state only.
REQ-028 SHALL, after reset, present read_data1=read_data2=0, busy1=busy2=0, busy_count=0.

Verification
REQ-029 SHALL cover: reset, then write reg 5=0xDEADBEEF; next cycle read1=5 -> read_data1=0xDEADBEEF, busy1=0.
REQ-030 SHALL cover: BYPASS=1, write reg 7=0x12345678 with read2=7 same cycle -> read_data2=0x12345678 before edge; BYPASS=0 -> old value 0 until edge.
REQ-031 SHALL cover: claim reg 3 -> busy1=1 for read1=3, busy_count=1; later write reg 3=0xA5 -> busy1=0, busy_count=0, data 0xA5.
REQ-032 SHALL cover: claim and write reg 9 same cycle with data 0x55 -> after edge busy=1, data 0x55, busy_count=1.
REQ-033 SHALL cover: ZERO_REG=1, write reg 0=0xFFFFFFFF and claim reg 0 -> read_data=0, busy=0, busy_count unchanged.
REQ-034 SHALL cover: claim all DEPTH-1 nonzero registers (busy_count=31), assert reset with simultaneous write reg 4=0x1 -> after edge busy_count=0, reg 4 reads 0.

Source files
------------

// File: rtl/regfile_sb.sv
// Register file with a per-register scoreboard: claims mark a register as awaiting a
// result, writebacks store data and clear the mark. Two combinational read ports.
module regfile_sb #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    read1,
    input  logic [AW-1:0]    read2,
    output logic [WIDTH-1:0] read_data1,
    output logic [WIDTH-1:0] read_data2,
    output logic             busy1,
    output logic             busy2,
    input  logic [AW-1:0]    write,
    input  logic [WIDTH-1:0] write_data,
    input  logic             write_enable,
    input  logic [AW-1:0]    claim,
    input  logic             claim_enable,
    output logic [AW:0]      busy_count
);

    // An address is usable if it exists and is not the hardwired zero register.
    function automatic logic addr_legal(input logic [AW-1:0] a);
        return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [AW:0]      busy_count_q;
    logic [AW:0]      busy_count_d;
    logic             wr_ok;
    logic             cl_ok;

    assign wr_ok = write_enable && addr_legal(write);
    assign cl_ok = claim_enable && addr_legal(claim);

    // Claim is applied after the writeback clear so a same-cycle claim keeps the bit set.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok) begin
            busy_d[write] = 1'b0;
        end
        if (cl_ok) begin
            busy_d[claim] = 1'b1;
        end
        busy_count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_count_d = busy_count_d + (AW+1)'(busy_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            if (wr_ok) begin
                data_q[write] <= write_data;
            end
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign busy_count = busy_count_q;

    logic [AW-1:0] rd_addr [2];
    assign rd_addr[0] = read1;
    assign rd_addr[1] = read2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic             hit;
            logic [WIDTH-1:0] data;
            logic             busy;

            // Forwarding is disabled during reset so outputs show stored state only.
            assign hit = (BYPASS != 0) && wr_ok && !reset && (write == rd_addr[gi]);

            always_comb begin
                data = '0;
                busy = 1'b0;
                if (hit) begin
                    data = write_data;
                    busy = cl_ok && (claim == write);
                end else if (addr_legal(rd_addr[gi])) begin
                    data = data_q[rd_addr[gi]];
                    busy = busy_q[rd_addr[gi]];
                end
            end
        end
    endgenerate

    assign read_data1 = g_rd[0].data;
    assign read_data2 = g_rd[1].data;
    assign busy1      = g_rd[0].busy;
    assign busy2      = g_rd[1].busy;

endmodule
